dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the far end of the IEU load/store memory interface.
- Accepts one read or write request at a time and waits a configurable number of cycles.
- Commits byte-enabled writes, or returns the full 32-bit word for reads, then pulses ready.
- Out-of-range accesses raise an error flag instead of touching storage.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words stored; legal byte addresses are 0 to DEPTH_WORDS*4-1.
WAIT_STATES, 1, extra busy cycles between accept and completion; 0 is legal.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  reset, asynchronous, active-low (0 = reset).
mem_req  in  1  request valid; the requester holds it and all request fields stable until mem_ready.
mem_rw_mode  in  1  1 = read, 0 = write.
mem_addr  in  32  byte address.
mem_write_data  in  32  write data, lane-aligned (byte lane n = bits 8n+7:8n).
mem_byte_en  in  4  write lane enables; on reads used only by the optional check.
mem_read_data  out  32  full word read; valid while mem_ready is high for a read.
mem_ready  out  1  one-cycle completion pulse.
mem_err  out  1  error for this access; valid only while mem_ready is high.

Behaviour:
- Reset (i_rst=0, async): state=IDLE, mem_ready=0, mem_err=0, mem_read_data=0, wait counter=0.
- Storage array is not cleared by reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE, mem_req=1 at a rising edge: latch addr, mode, data and byte_en; counter loads WAIT_STATES.
  - WAIT_STATES>0: go to BUSY.
  - WAIT_STATES=0: go to DONE.
- BUSY: counter decrements each cycle; on the edge where counter==1, transition to DONE.
- The access is performed on the edge entering DONE; outputs are registered on that edge.
- DONE lasts exactly one cycle:
  - mem_ready=1 and mem_err as computed.
  - Read: mem_read_data = stored word at index addr[log2(DEPTH_WORDS)+1:2].
  - Write: mem_read_data=0; only lanes with byte_en=1 are updated.
- DONE always returns to IDLE. mem_req is ignored in BUSY and DONE.
- Latency: mem_ready rises WAIT_STATES+1 cycles after the accepting edge.
- Throughput: a continuously held mem_req gives one access per WAIT_STATES+2 cycles.
- Range check: addr >= DEPTH_WORDS*4 gives mem_err=1. No write occurs, and a read returns 0.
- A write with byte_en=4'b0000 completes normally (ready, err=0) with no storage change.
- addr[1:0] does not affect the word index.
- Reset asserted in BUSY abandons the access: no write is committed and no ready pulse is produced.
- Reset asserted in DONE: outputs clear immediately. A write committed on the edge entering DONE persists.
- Outside DONE, mem_ready=0 and mem_err=0. mem_read_data holds its value until the next completion.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined: each accepted request (read or write) is checked against the legal byte_en/address pairings:
  - 0001 with addr[1:0]=00, 0010 with 01, 0100 with 10, 1000 with 11.
  - 0011 with 00, 1100 with 10.
  - 1111 with 00.
  - Any other combination is misaligned.
- Misaligned access: completes with normal latency, mem_err=1, no write, read data 0.
- Not defined: no check; addr[1:0] and the byte_en pattern are never an error source; only range errors set mem_err.

Test Plan:
1. WAIT_STATES=1. Write 0xDEADBEEF, be=1111, addr=0x10, then read 0x10 → each ready 2 cycles after accept; read data 0xDEADBEEF, err=0; write completion shows read_data=0.
2. After scenario 1, write 0x00AB0000, be=0100, addr=0x12, then read 0x10 → 0xDEABBEEF.
3. Write 0x12345678 to addr 0x1000 (DEPTH_WORDS=1024) → ready with err=1; read 0x1000 → data 0, err=1; read 0x0 → unchanged.
4. Write 0xCAFEF00D to addr 0x20, assert i_rst=0 in the BUSY cycle, release, then read 0x20 → no ready during the aborted access; read returns the prior contents.
5. WAIT_STATES=0 with mem_req held high for two reads → ready 1 cycle after each accept; second accept on the edge after DONE; ready pulses exactly 2 cycles apart.
6. Write be=1111, addr=0x11 → with DMEM_ALIGN_CHECK_EN: err=1 and word 0x10 unchanged; without: err=0 and word 0x10 overwritten.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES busy cycles, then a one-cycle ready pulse.
// Optional macro DMEM_ALIGN_CHECK_EN adds a byte-enable/address alignment check.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        mem_req,
    input  logic        mem_rw_mode,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic [3:0]  mem_byte_en,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    req_t           req_q, req_d, live_c, acc_c;
    logic [31:0]    mem [DEPTH_WORDS];

    logic           enter_done_c;
    logic           range_err_c;
    logic           align_err_c;
    logic           acc_err_c;
    logic           we_c;
    logic [AW-1:0]  idx_c;
    logic [31:0]    rdata_d;
    logic           ready_d;
    logic           err_d;

`ifdef DMEM_ALIGN_CHECK_EN
    function automatic logic align_ok(input logic [3:0] be, input logic [1:0] lo);
        case ({be, lo})
            6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11,
            6'b0011_00, 6'b1100_10, 6'b1111_00: align_ok = 1'b1;
            default:                            align_ok = 1'b0;
        endcase
    endfunction
`endif

    always_comb begin
        live_c = {mem_rw_mode, mem_addr, mem_write_data, mem_byte_en};
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    req_d   = live_c;
                    cnt_d   = CW'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Access evaluation; with zero wait states the access happens on the accepting edge
    always_comb begin
        acc_c        = (state_q == IDLE) ? live_c : req_q;
        enter_done_c = (state_d == DONE) && (state_q != DONE);
        idx_c        = acc_c.addr[AW+1:2];
        range_err_c  = ({1'b0, acc_c.addr} >= LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
        align_err_c  = ~align_ok(acc_c.be, acc_c.addr[1:0]);
`else
        align_err_c  = 1'b0;
`endif
        acc_err_c    = range_err_c | align_err_c;
        we_c         = enter_done_c & ~acc_c.rw & ~acc_err_c & i_rst;
        ready_d      = enter_done_c;
        err_d        = enter_done_c & acc_err_c;
        rdata_d      = mem_read_data;
        if (enter_done_c) begin
            rdata_d = (acc_c.rw && !acc_err_c) ? mem[idx_c] : 32'h0;
        end
    end

    // Registered outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mem_ready     <= 1'b0;
            mem_err       <= 1'b0;
            mem_read_data <= '0;
        end else begin
            mem_ready     <= ready_d;
            mem_err       <= err_d;
            mem_read_data <= rdata_d;
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge i_clk) begin
        if (we_c) begin
            for (int n = 0; n < 4; n++) begin
                if (acc_c.be[n]) begin
                    mem[idx_c][8*n +: 8] <= acc_c.wdata[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state, one with none.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic ALIGN = 1'b1;
`else
    localparam logic ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, req1, rw1, rdy1, err1;
    logic [31:0] addr1, wd1, rd1;
    logic [3:0]  be1;
    logic        rst0, req0, rw0, rdy0, err0;
    logic [31:0] addr0, wd0, rd0;
    logic [3:0]  be0;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst1), .mem_req(req1), .mem_rw_mode(rw1),
        .mem_addr(addr1), .mem_write_data(wd1), .mem_byte_en(be1),
        .mem_read_data(rd1), .mem_ready(rdy1), .mem_err(err1)
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst0), .mem_req(req0), .mem_rw_mode(rw0),
        .mem_addr(addr0), .mem_write_data(wd0), .mem_byte_en(be0),
        .mem_read_data(rd0), .mem_ready(rdy0), .mem_err(err0)
    );

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic cur_rdy(input bit sel);
        return sel ? rdy1 : rdy0;
    endfunction

    function automatic logic cur_err(input bit sel);
        return sel ? err1 : err0;
    endfunction

    function automatic logic [31:0] cur_rd(input bit sel);
        return sel ? rd1 : rd0;
    endfunction

    task automatic drive(input bit sel, input logic req, input logic rw,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        if (sel) begin
            req1 = req; rw1 = rw; addr1 = a; wd1 = d; be1 = be;
        end else begin
            req0 = req; rw0 = rw; addr0 = a; wd0 = d; be0 = be;
        end
    endtask

    // One complete access: latency, data, error, and single-cycle ready
    task automatic access(input bit sel, input string name, input logic rw,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic [31:0] exp_rd, input logic exp_err);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        drive(sel, 1'b1, rw, a, d, be);
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            got = cur_rdy(sel);
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no ready want ready within 20 cycles", name);
        end else begin
            chk({name, "_lat"}, 32'(n), sel ? 32'd2 : 32'd1);
            chk({name, "_rd"}, cur_rd(sel), exp_rd);
            chk({name, "_err"}, 32'(cur_err(sel)), 32'(exp_err));
            @(posedge clk);
            #1;
            chk({name, "_pulse"}, 32'(cur_rdy(sel)), 32'd0);
        end
    endtask

    initial begin
        int   cnt;
        int   pos[2];
        logic got;

        vt[0]  = '{1'b0, 32'h010, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
        vt[1]  = '{1'b1, 32'h010, 32'h0,        4'b1111, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b0, 32'h012, 32'h00AB0000, 4'b0100, 32'h0,        1'b0};
        vt[3]  = '{1'b1, 32'h010, 32'h0,        4'b1111, 32'hDEABBEEF, 1'b0};
        vt[4]  = '{1'b1, 32'h013, 32'h0,        4'b1000, 32'hDEABBEEF, 1'b0};
        vt[5]  = '{1'b0, 32'h000, 32'h11223344, 4'b1111, 32'h0,        1'b0};
        vt[6]  = '{1'b0, 32'h1000, 32'h12345678, 4'b1111, 32'h0,       1'b1};
        vt[7]  = '{1'b1, 32'h1000, 32'h0,       4'b1111, 32'h0,        1'b1};
        vt[8]  = '{1'b1, 32'h000, 32'h0,        4'b1111, 32'h11223344, 1'b0};
        vt[9]  = '{1'b0, 32'h014, 32'h55555555, 4'b1111, 32'h0,        1'b0};
        vt[10] = '{1'b0, 32'h014, 32'hFFFFFFFF, 4'b0000, 32'h0,        ALIGN};
        vt[11] = '{1'b1, 32'h014, 32'h0,        4'b1111, 32'h55555555, 1'b0};
        vt[12] = '{1'b0, 32'hFFC, 32'h0BADF00D, 4'b1111, 32'h0,        1'b0};
        vt[13] = '{1'b1, 32'hFFC, 32'h0,        4'b1111, 32'h0BADF00D, 1'b0};
        vt[14] = '{1'b1, 32'hFFF, 32'h0,        4'b1000, 32'h0BADF00D, 1'b0};

        rst1 = 1'b1; rst0 = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #2;
        rst1 = 1'b0; rst0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rdy1), 32'd0);
        chk("rst_err",   32'(err1), 32'd0);
        chk("rst_rdata", rd1, 32'h0);
        chk("rst0_ready", 32'(rdy0), 32'd0);
        @(negedge clk);
        rst1 = 1'b1; rst0 = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            access(1'b1, $sformatf("vec%0d", i), vt[i].rw, vt[i].addr, vt[i].wd, vt[i].be,
                   vt[i].exp_rd, vt[i].exp_err);
        end

        // Reset while BUSY abandons the write and produces no ready
        access(1'b1, "pre20", 1'b0, 32'h20, 32'h01020304, 4'b1111, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 4'b1111);
        @(posedge clk);
        #1;
        chk("abort_busy_rdy", 32'(rdy1), 32'd0);
        rst1 = 1'b0;
        #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (rdy1) cnt++;
        end
        chk("abort_no_ready", 32'(cnt), 32'd0);
        @(negedge clk);
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        access(1'b1, "abort_rd20", 1'b1, 32'h20, 32'h0, 4'b1111, 32'h01020304, 1'b0);

        // Reset while DONE clears outputs but keeps the committed write
        drive(1'b1, 1'b1, 1'b0, 32'h24, 32'h13572468, 4'b1111);
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
            got = rdy1;
        end
        chk("done_rst_seen", 32'(got), 32'd1);
        rst1 = 1'b0;
        #1;
        chk("done_rst_rdy", 32'(rdy1), 32'd0);
        chk("done_rst_err", 32'(err1), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        access(1'b1, "done_rd24", 1'b1, 32'h24, 32'h0, 4'b1111, 32'h13572468, 1'b0);

        // Zero wait states with request held: ready pulses two cycles apart
        access(1'b0, "z_w8", 1'b0, 32'h8, 32'hA5A5A5A5, 4'b1111, 32'h0, 1'b0);
        access(1'b0, "z_oor", 1'b0, 32'h40, 32'h0, 4'b1111, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 32'h8, 32'h0, 4'b1111);
        cnt = 0;
        pos[0] = 0;
        pos[1] = 0;
        for (int e = 1; e <= 6 && cnt < 2; e++) begin
            @(posedge clk);
            #1;
            if (rdy0) begin
                pos[cnt] = e;
                chk($sformatf("z_hold_rd%0d", cnt), rd0, 32'hA5A5A5A5);
                cnt++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("z_hold_count", 32'(cnt), 32'd2);
        chk("z_hold_first", 32'(pos[0]), 32'd1);
        chk("z_hold_second", 32'(pos[1]), 32'd3);
        @(posedge clk);
        #1;

        // Misaligned full-word write
        access(1'b1, "mis_w11", 1'b0, 32'h11, 32'h77777777, 4'b1111, 32'h0, ALIGN);
        access(1'b1, "mis_rd10", 1'b1, 32'h10, 32'h0, 4'b1111,
               ALIGN ? 32'hDEABBEEF : 32'h77777777, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
